poly_ram_reader: RTL and testbench

Streaming reader for `poly_ram`: the read-side counterpart to the write path that fills polynomial memory. On a start pulse it fetches `len` coefficient pairs starting at `base_addr`, using both `poly_ram` read ports in parallel (even and odd address). It returns the pairs on a valid/ready output stream with a last-beat marker. It sits between `poly_ram` and downstream consumers (NTT butterfly, compress/encode) and absorbs consumer back-pressure with a small credit-controlled FIFO.

---
 rtl/kyber_pkg.sv | 21 ++
 rtl/pair_fifo.sv | 67 ++++++
 rtl/poly_ram_reader.sv | 139 +++++++++++++
 tb/tb_poly_ram_reader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared types and widths for the polynomial memory read path.
// Holds the reader state encoding and the coefficient-pair entry layout.
package kyber_pkg;

    localparam int COEFF_W = 16;
    localparam int ADDR_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } reader_state_t;

    typedef struct packed {
        logic [COEFF_W-1:0] d0;
        logic [COEFF_W-1:0] d1;
        logic               last;
    } pair_t;

endpackage

// File: rtl/pair_fifo.sv
// Small synchronous FIFO for coefficient pairs; same-cycle push and pop allowed.
// Head entry is visible combinationally so the consumer sees it without an extra cycle.
module pair_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 push_d,
    input  logic                         pop,
    output logic [W-1:0]                 head_d,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count_reg == '0);
    assign full   = (count_reg == FULL_CNT);
    assign count  = count_reg;
    assign head_d = mem_reg[rd_ptr_reg];
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= bump(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= bump(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/poly_ram_reader.sv
// Streams len coefficient pairs out of poly_ram using both read ports per cycle.
// Reads are credit-gated so the pair FIFO absorbs consumer back-pressure without overflow.
module poly_ram_reader
    import kyber_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int DW         = COEFF_W,
    parameter int AW         = ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          r1_en,
    output logic          r2_en,
    output logic [AW-1:0] r1_addr,
    output logic [AW-1:0] r2_addr,
    input  logic [DW-1:0] r1_d,
    input  logic [DW-1:0] r2_d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_d0,
    output logic [DW-1:0] out_d1,
    output logic          out_last
);
    localparam int FW = 2 * DW + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] ADDR_MASK = AW'(DEPTH - 1);
    localparam logic [CW:0]   CREDITS   = (CW + 1)'(FIFO_DEPTH);

    reader_state_t state_reg, state_next;
    logic [AW-1:0] base_reg;
    logic [AW-1:0] len_reg;
    logic [AW-1:0] issue_cnt_reg, issue_cnt_next;
    logic          inflight_reg;
    logic          inflight_last_reg;

    logic          credit_ok;
    logic          issue;
    logic          issue_last;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [FW-1:0] head_d;
    logic [AW-1:0] even_addr;

    // Count the read still in flight so a landing response always has a free slot.
    assign credit_ok  = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg}) < CREDITS;
    assign issue      = (state_reg == READ) && credit_ok && !fifo_full;
    assign issue_last = issue && (issue_cnt_reg == len_reg - 1'b1);
    assign even_addr  = (base_reg + {issue_cnt_reg[AW-2:0], 1'b0}) & ADDR_MASK;

    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == FIN);
    assign r1_en   = issue;
    assign r2_en   = issue;
    assign r1_addr = issue ? even_addr : '0;
    assign r2_addr = issue ? ((even_addr + 1'b1) & ADDR_MASK) : '0;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_d0    = fifo_empty ? '0 : head_d[DW-1:0];
    assign out_d1    = fifo_empty ? '0 : head_d[2*DW-1:DW];
    assign out_last  = fifo_empty ? 1'b0 : head_d[FW-1];

    always_comb begin
        state_next     = state_reg;
        issue_cnt_next = issue_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = (len == '0) ? FIN : READ;
                    issue_cnt_next = '0;
                end
            end
            READ: begin
                if (issue) begin
                    issue_cnt_next = issue_cnt_reg + 1'b1;
                end
                if (issue_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            base_reg          <= '0;
            len_reg           <= '0;
            issue_cnt_reg     <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            issue_cnt_reg     <= issue_cnt_next;
            inflight_reg      <= issue;
            inflight_last_reg <= issue_last;
            if (state_reg == IDLE && start) begin
                base_reg <= base_addr;
                len_reg  <= len;
            end
        end
    end

    // Read data lands one cycle after issue and goes straight into the FIFO.
    pair_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (inflight_reg),
        .push_d ({inflight_last_reg, r2_d, r1_d}),
        .pop    (pop),
        .head_d (head_d),
        .count  (fifo_count),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

endmodule

// File: tb/tb_poly_ram_reader.sv
// Directed self-checking bench for poly_ram_reader with a 64-word RAM model holding ram[i]=i.
module tb_poly_ram_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        r1_en;
    logic        r2_en;
    logic [15:0] r1_addr;
    logic [15:0] r2_addr;
    logic [15:0] r1_d;
    logic [15:0] r2_d;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_d0;
    logic [15:0] out_d1;
    logic        out_last;

    logic [15:0] ram [64];
    int total;
    int bad;

    poly_ram_reader #(
        .DEPTH      (64),
        .DW         (16),
        .AW         (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .r1_en     (r1_en),
        .r2_en     (r2_en),
        .r1_addr   (r1_addr),
        .r2_addr   (r2_addr),
        .r1_d      (r1_d),
        .r2_d      (r2_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d0    (out_d0),
        .out_d1    (out_d1),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (r1_en) r1_d <= ram[r1_addr[5:0]];
        if (r2_en) r2_d <= ram[r2_addr[5:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Starts a job in the current cycle and follows it to done.
    // hold: out_ready stays 0 through this cycle number; spur: cycle carrying a stray start.
    task automatic run_job(input string tag, input int base, input int n, input int hold, input int spur);
        int cyc;
        int got;
        int reads;
        int first_valid;
        int done_cyc;
        logic busy_at_done;
        logic stalled;
        logic [15:0] h0;
        logic [15:0] h1;
        logic hl;
        start = 1'b1;
        base_addr = 16'(base);
        len = 16'(n);
        out_ready = 1'b0;
        step();
        cyc = 1; got = 0; reads = 0; first_valid = -1; done_cyc = -1;
        busy_at_done = 1'b0; stalled = 1'b0; h0 = '0; h1 = '0; hl = 1'b0;
        while (done_cyc < 0 && cyc < 300) begin
            start = (cyc == spur);
            if (cyc == spur) begin
                base_addr = 16'd30;
                len = 16'd2;
            end
            out_ready = (cyc > hold);
            if (r1_en) begin
                chk({tag, " r1_addr"}, 32'(r1_addr), 32'((base + 2 * reads) & 63));
                chk({tag, " r2_addr"}, 32'(r2_addr), 32'((base + 2 * reads + 1) & 63));
                chk({tag, " r2_en"}, 32'(r2_en), 32'd1);
                reads++;
            end
            if (hold > 0 && cyc == hold) chk({tag, " reads_at_stall"}, 32'(reads), 32'd4);
            if (stalled) chk({tag, " stall_hold"}, {out_valid, out_d0, out_d1, out_last},
                              {1'b1, h0, h1, hl});
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                $display("beat %s k=%0d d0=%0d d1=%0d last=%0b cyc=%0d",
                         tag, got, out_d0, out_d1, out_last, cyc);
                chk({tag, " d0"}, 32'(out_d0), 32'((base + 2 * got) & 63));
                chk({tag, " d1"}, 32'(out_d1), 32'((base + 2 * got + 1) & 63));
                chk({tag, " last"}, 32'(out_last), 32'(got == n - 1));
                got++;
            end
            stalled = out_valid && !out_ready;
            h0 = out_d0; h1 = out_d1; hl = out_last;
            if (done) begin
                done_cyc = cyc;
                busy_at_done = busy;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, 32'(done_cyc >= 0), 32'd1);
        chk({tag, " beats"}, 32'(got), 32'(n));
        chk({tag, " reads"}, 32'(reads), 32'(n));
        if (hold == 0) chk({tag, " done_cyc"}, 32'(done_cyc), (n == 0) ? 32'd1 : 32'(n + 3));
        if (hold == 0 && n > 0) chk({tag, " first_valid"}, 32'(first_valid), 32'd3);
        if (n == 0) chk({tag, " busy_in_fin"}, 32'(busy_at_done), 32'd1);
        chk({tag, " idle_after"}, {busy, done, out_valid}, 32'd0);
        $display("job %s base=%0d len=%0d done_cyc=%0d beats=%0d", tag, base, n, done_cyc, got);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " r_en"}, {r1_en, r2_en}, 32'd0);
        chk({tag, " r_addr"}, {r1_addr, r2_addr}, 32'd0);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " out_d"}, {out_d0, out_d1}, 32'd0);
        chk({tag, " out_last"}, 32'(out_last), 32'd0);
    endtask

    initial begin
        logic quiet;
        total = 0;
        bad = 0;
        for (int i = 0; i < 64; i++) ram[i] = 16'(i);
        reset = 1'b0;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        out_ready = 1'b0;
        step();
        chk_reset_vals("por");
        step();
        reset = 1'b1;
        step();
        chk_reset_vals("post_por");

        run_job("basic", 0, 4, 0, -1);
        run_job("wrap", 62, 2, 0, -1);
        run_job("backpressure", 0, 8, 20, -1);
        run_job("zero_len", 0, 0, 0, -1);
        run_job("ignored_start", 0, 4, 0, 2);

        start = 1'b1;
        base_addr = 16'd0;
        len = 16'd8;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        #1 reset = 1'b0;
        #1;
        chk_reset_vals("midjob_reset");
        @(posedge clk);
        #1 reset = 1'b1;
        quiet = 1'b1;
        repeat (10) begin
            if (done || out_valid || r1_en) quiet = 1'b0;
            step();
        end
        chk("after_reset_quiet", 32'(quiet), 32'd1);
        run_job("fresh", 10, 1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
